// File: rtl/debounce_pkg.sv
// Shared FSM encoding and width helpers for the debounce scheduler and its tick generator.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam int TICK_COUNTER_W = 32;

  function automatic int ptr_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int count_width(input int stable_samples);
    return $clog2(stable_samples + 1);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable slow-strobe generator: one tick every CLOCK_FREQUENCY/(rate+1)+1 cycles,
// halted while rate is zero.
module sample_tick_gen
  import debounce_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic [7:0] i_w_rate,
  output logic       o_w_tick
);

  localparam logic [TICK_COUNTER_W-1:0] FREQ = TICK_COUNTER_W'(CLOCK_FREQUENCY);

  logic [TICK_COUNTER_W-1:0] div_s;
  logic [TICK_COUNTER_W-1:0] count_r;
  logic                      tick_r;

  // Divisor tracks the live rate, so a rate change applies to the period already in progress.
  always_comb begin
    div_s = FREQ / ({24'd0, i_w_rate} + 32'd1);
  end

  // Free-running counter with registered tick; held at zero while halted.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (i_w_rate == 8'd0) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (count_r >= div_s) begin
      count_r <= '0;
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r + 32'd1;
      tick_r  <= 1'b0;
    end
  end

  assign o_w_tick = tick_r;

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin multi-channel debouncer: one shared tick and one compare/update datapath
// service every channel in turn, producing clean levels and press/release strobes.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int CHANNELS        = 4,
  parameter int STABLE_SAMPLES  = 4
) (
  input  logic                i_w_clk,
  input  logic                i_w_reset,
  input  logic [7:0]          i_w_rate,
  input  logic [CHANNELS-1:0] i_w_in,
  output logic [CHANNELS-1:0] o_w_level,
  output logic [CHANNELS-1:0] o_w_press,
  output logic [CHANNELS-1:0] o_w_release,
  output logic                o_w_tick,
  output logic                o_w_overrun
);

  localparam int PTR_W = ptr_width(CHANNELS);
  localparam int CNT_W = count_width(STABLE_SAMPLES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_SAMPLES - 1);

  logic [CHANNELS-1:0] sync1_r;
  logic [CHANNELS-1:0] sync2_r;
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] press_r;
  logic [CHANNELS-1:0] release_r;
  logic [CNT_W-1:0]    count_r [CHANNELS];
  logic [PTR_W-1:0]    ptr_r;
  state_t              state_r;
  state_t              state_next_s;
  logic                pending_r;
  logic                overrun_r;
  logic                sample_r;
  logic                lv_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                tick_s;
  logic                accept_s;

  sample_tick_gen #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_tick (
    .i_w_clk  (i_w_clk),
    .i_w_reset(i_w_reset),
    .i_w_rate (i_w_rate),
    .o_w_tick (tick_s)
  );

  // Two-flop synchronizer for the raw button inputs.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= i_w_in;
      sync2_r <= sync1_r;
    end
  end

  // Scheduler next state; a service starts on a fresh tick or a remembered one.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (tick_s || pending_r) begin
          accept_s     = 1'b1;
          state_next_s = ST_SAMPLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_SAMPLE: state_next_s = ST_UPDATE;
      ST_UPDATE: state_next_s = ST_WAIT;
      default:   state_next_s = ST_WAIT;
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // One-deep tick memory while busy; a second busy tick is dropped and flagged.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (state_r == ST_WAIT) begin
        pending_r <= 1'b0;
      end else if (tick_s && pending_r) begin
        overrun_r <= 1'b1;
      end else if (tick_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Shared compare/update datapath: latch one channel, then apply the stability rule.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      ptr_r     <= '0;
      sample_r  <= 1'b0;
      lv_r      <= 1'b0;
      cnt_r     <= '0;
      level_r   <= '0;
      press_r   <= '0;
      release_r <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        count_r[k] <= '0;
      end
    end else begin
      press_r   <= '0;
      release_r <= '0;
      case (state_r)
        ST_SAMPLE: begin
          sample_r <= sync2_r[ptr_r];
          lv_r     <= level_r[ptr_r];
          cnt_r    <= count_r[ptr_r];
        end
        ST_UPDATE: begin
          if (sample_r == lv_r) begin
            count_r[ptr_r] <= '0;
          end else if (cnt_r == LAST_CNT) begin
            level_r[ptr_r]   <= sample_r;
            count_r[ptr_r]   <= '0;
            press_r[ptr_r]   <= sample_r;
            release_r[ptr_r] <= ~sample_r;
          end else begin
            count_r[ptr_r] <= cnt_r + CNT_W'(1);
          end
          ptr_r <= (ptr_r == LAST_PTR) ? '0 : ptr_r + PTR_W'(1);
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  assign o_w_level   = level_r;
  assign o_w_press   = press_r;
  assign o_w_release = release_r;
  assign o_w_tick    = accept_s;
  assign o_w_overrun = overrun_r;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Self-checking bench: a table of per-service vectors fed through a scoreboard queue,
// plus hand-written reset, overrun and rate-change sequences.
module tb_debounce_scheduler;
  import debounce_pkg::*;

  localparam int CF = 16;
  localparam int CH = 4;
  localparam int SS = 3;
  localparam int NROWS = 53;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rate = 8'd0;
  logic [CH-1:0] din = 4'hF;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_v;
  logic          tick;
  logic          overrun;

  debounce_scheduler #(
    .CLOCK_FREQUENCY(CF),
    .CHANNELS       (CH),
    .STABLE_SAMPLES (SS)
  ) dut (
    .i_w_clk    (clk),
    .i_w_reset  (rst_n),
    .i_w_rate   (rate),
    .i_w_in     (din),
    .o_w_level  (level),
    .o_w_press  (press),
    .o_w_release(release_v),
    .o_w_tick   (tick),
    .o_w_overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int tick_total = 0;
  int over_total = 0;
  int press_total = 0;
  int rel_total = 0;
  int strobe_viol = 0;

  typedef struct {
    logic [CH-1:0] din;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rel;
  } vec_t;

  typedef struct {
    int            row;
    logic [CH-1:0] lvl;
    logic [CH-1:0] prs;
    logic [CH-1:0] rel;
  } exp_t;

  vec_t tbl [NROWS];
  exp_t sb [$];

  // Output event counters and strobe-exclusivity watch, sampled on the falling edge.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (tick) tick_total <= tick_total + 1;
    if (overrun) over_total <= over_total + 1;
    press_total <= press_total + $countones(press);
    rel_total <= rel_total + $countones(release_v);
    if (($countones(press | release_v) > 1) || ((press & release_v) != 4'd0))
      strobe_viol <= strobe_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!tick && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({name, "_tick_seen"}, 32'(tick), 32'd1);
    t = cycle;
  endtask

  task automatic fill(input int lo, input int hi, input logic [CH-1:0] d, input logic [CH-1:0] l);
    for (int r = lo; r <= hi; r++) begin
      tbl[r].din = d;
      tbl[r].lvl = l;
      tbl[r].prs = 4'b0000;
      tbl[r].rel = 4'b0000;
    end
  endtask

  initial begin
    int t;
    int prev_t;
    int base_tick;
    int base_over;
    int base_press;
    int base_rel;
    exp_t e;

    // Service k handles channel k%4; in[2] held high, in[0] bounces then settles.
    fill(0, 9, 4'b0100, 4'b0000);
    fill(10, 39, 4'b0100, 4'b0100);
    fill(40, 51, 4'b0100, 4'b0101);
    fill(52, 52, 4'b0100, 4'b0100);
    tbl[10].prs = 4'b0100;
    tbl[40].prs = 4'b0001;
    tbl[52].rel = 4'b0001;
    foreach (tbl[r]) begin
      if (r == 11 || r == 12 || r == 15 || r == 16 || r == 18 ||
          (r >= 21 && r <= 24) || (r >= 29 && r <= 40))
        tbl[r].din = 4'b0101;
    end

    // Reset held with all inputs high.
    repeat (3) @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_press", 32'(press), 32'd0);
    check("rst_release", 32'(release_v), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    base_tick = tick_total;
    repeat (100) @(negedge clk);
    check("halt_no_ticks", 32'(tick_total - base_tick), 32'd0);
    check("halt_level", 32'(level), 32'd0);

    // Table of services at rate 1 (div 8).
    din = tbl[0].din;
    rate = 8'd1;
    prev_t = 0;
    for (int k = 0; k < NROWS; k++) begin
      din = tbl[k].din;
      sb.push_back('{row: k, lvl: tbl[k].lvl, prs: tbl[k].prs, rel: tbl[k].rel});
      wait_tick($sformatf("row%0d", k), t);
      check($sformatf("row%0d_ptr", k), 32'(dut.ptr_r), 32'(k % CH));
      if (k > 0) check($sformatf("row%0d_period", k), 32'(t - prev_t), 32'd9);
      prev_t = t;
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("row%0d_level", e.row), 32'(level), 32'(e.lvl));
      check($sformatf("row%0d_press", e.row), 32'(press), 32'(e.prs));
      check($sformatf("row%0d_release", e.row), 32'(release_v), 32'(e.rel));
      @(negedge clk);
      check($sformatf("row%0d_strobe_width", e.row), 32'(press | release_v), 32'd0);
    end
    check("table_tick_total", 32'(tick_total), 32'(NROWS));
    check("table_press_total", 32'(press_total), 32'd2);
    check("table_release_total", 32'(rel_total), 32'd1);

    // Tick every cycle: one service per 3 cycles, one overrun per service.
    rate = 8'd255;
    repeat (12) @(negedge clk);
    base_tick = tick_total;
    base_over = over_total;
    base_press = press_total;
    base_rel = rel_total;
    repeat (30) @(negedge clk);
    check("ovr_services", 32'(tick_total - base_tick), 32'd10);
    check("ovr_overruns", 32'(over_total - base_over), 32'd10);
    check("ovr_level_hold", 32'(level), 32'b0100);
    check("ovr_no_strobes", 32'((press_total - base_press) + (rel_total - base_rel)), 32'd0);
    din = 4'b0000;
    base_press = press_total;
    base_rel = rel_total;
    repeat (60) @(negedge clk);
    check("ovr_level_release", 32'(level), 32'd0);
    check("ovr_release_count", 32'(rel_total - base_rel), 32'd1);
    check("ovr_press_count", 32'(press_total - base_press), 32'd0);

    // Reset during the flipping UPDATE of channel 1.
    rst_n = 1'b0;
    rate = 8'd1;
    din = 4'b0010;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_tick($sformatf("mid%0d", i), t);
    end
    check("mid_ptr", 32'(dut.ptr_r), 32'd1);
    check("mid_count_before", 32'(dut.count_r[1]), 32'd2);
    repeat (2) @(negedge clk);
    check("mid_in_update", 32'(dut.state_r), 32'(ST_UPDATE));
    rst_n = 1'b0;
    #1;
    check("mid_rst_press", 32'(press), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    base_press = press_total;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_count_after", 32'(dut.count_r[1]), 32'd0);
    repeat (8) @(negedge clk);
    check("mid_no_press", 32'(press_total - base_press), 32'd0);

    // Rate 1 -> 3 with the tick counter already past the new divisor.
    t = 0;
    while (dut.u_tick.count_r != 32'd6 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rate_counter_at6", 32'(dut.u_tick.count_r), 32'd6);
    rate = 8'd3;
    @(negedge clk);
    check("rate_change_tick", 32'(tick), 32'd1);
    prev_t = cycle;
    wait_tick("rate_next", t);
    check("rate_new_period", 32'(t - prev_t), 32'd5);

    @(negedge clk);
    check("strobe_exclusive", 32'(strobe_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
